// File: rtl/fb_pkg.sv
// Shared types and constants for the 80x60 cell frame buffer scan-out path.
// Timing constants describe 640x480@60 on a 25.175 MHz pixel clock.
package fb_pkg;

    // Frame buffer geometry: one RGB332 byte per 8x8 pixel cell
    localparam int FB_ADDR_W  = 13;
    localparam int FB_DATA_W  = 8;
    localparam int FB_COLS    = 80;
    localparam int FB_ROWS    = 60;
    localparam int FB_DEPTH   = FB_COLS * FB_ROWS;
    localparam int CELL_SHIFT = 3;

    // Horizontal timing in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    // Counter and cell index widths
    localparam int HCNT_W = 10;
    localparam int VCNT_W = 10;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 7;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_data_t;
    typedef logic [HCNT_W-1:0]    hcnt_t;
    typedef logic [VCNT_W-1:0]    vcnt_t;
    typedef logic [ROW_W-1:0]     cell_row_t;
    typedef logic [COL_W-1:0]     cell_col_t;

    // First address past the end of the buffer; writes at or above it are dropped
    localparam fb_addr_t FB_LIMIT = fb_addr_t'(FB_DEPTH);

    // Stage-0 decode of the raster position
    typedef struct packed {
        logic      active;
        logic      hs;
        logic      vs;
        cell_row_t row;
        cell_col_t col;
    } scan_ctl_t;

    // row*80 + col without a multiplier: 80 = 64 + 16
    function automatic fb_addr_t cell_addr(input cell_row_t row, input cell_col_t col);
        fb_addr_t r;
        fb_addr_t c;
        r = fb_addr_t'(row);
        c = fb_addr_t'(col);
        return (r << 6) + (r << 4) + c;
    endfunction

endpackage

// File: rtl/fb_scanout_vga_timing.sv
// Raster counters for 640x480@60 and their stage-0 decode:
// active-video flag, sync windows and the 8x8 cell row/column indices.
module vga_timing
    import fb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    output scan_ctl_t ctl
);

    localparam hcnt_t H_LAST     = hcnt_t'(H_TOTAL - 1);
    localparam vcnt_t V_LAST     = vcnt_t'(V_TOTAL - 1);
    localparam hcnt_t H_ACT_END  = hcnt_t'(H_ACTIVE);
    localparam vcnt_t V_ACT_END  = vcnt_t'(V_ACTIVE);
    localparam hcnt_t HS_FIRST   = hcnt_t'(HS_START);
    localparam hcnt_t HS_LAST    = hcnt_t'(HS_END);
    localparam vcnt_t VS_FIRST   = vcnt_t'(VS_START);
    localparam vcnt_t VS_LAST    = vcnt_t'(VS_END);

    hcnt_t hcnt_reg;
    vcnt_t vcnt_reg;

    // Pixel and line counters; the line counter steps when the pixel counter wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (hcnt_reg == H_LAST) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
        end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
        end
    end

    // Decode the current position; row/col truncate outside active video
    // where nobody consumes them
    always_comb begin
        ctl        = '0;
        ctl.active = (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
        ctl.hs     = (hcnt_reg >= HS_FIRST) && (hcnt_reg <= HS_LAST);
        ctl.vs     = (vcnt_reg >= VS_FIRST) && (vcnt_reg <= VS_LAST);
        ctl.row    = vcnt_reg[CELL_SHIFT +: ROW_W];
        ctl.col    = hcnt_reg[CELL_SHIFT +: COL_W];
    end

endmodule

// File: rtl/fb_scanout.sv
// Frame buffer scan-out: owns the frame buffer's single address/write port,
// fetches one RGB332 byte per 8x8 cell during active video and hands the
// port to a queued writer only while the fetch side is blanking.
// Pipeline: stage 0 = counters, stage 1 = port register (fetch or write),
// stage 2 = pins. The RAM's own output register supplies the pixel byte in
// stage 2, so syncs, de and pixel all leave two cycles after the counters.
// Optional build macro FB_SCANOUT_TESTPAT_EN adds input i_test_pat, which
// replaces memory pixels with a row/column XOR pattern.
module fb_scanout
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_rst,
    output logic [FB_ADDR_W-1:0] o_fb_addr,
    output logic                 o_fb_wen,
    output logic [FB_DATA_W-1:0] o_fb_wdata,
    input  logic [FB_DATA_W-1:0] i_fb_rdata,
    input  logic                 i_wr_req,
    input  logic [FB_ADDR_W-1:0] i_wr_addr,
    input  logic [FB_DATA_W-1:0] i_wr_data,
`ifdef FB_SCANOUT_TESTPAT_EN
    input  logic                 i_test_pat,
`endif
    output logic                 o_wr_ack,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [FB_DATA_W-1:0] o_pixel
);

    scan_ctl_t ctl0;

    logic active1_reg;
    logic hs1_reg;
    logic vs1_reg;

`ifdef FB_SCANOUT_TESTPAT_EN
    // Only the low five row bits feed the pattern
    logic [4:0]      row1_reg;
    logic [4:0]      row2_reg;
    cell_col_t       col1_reg;
    cell_col_t       col2_reg;
`endif

    vga_timing u_timing (
        .clk (clk),
        .rst (i_rst),
        .ctl (ctl0)
    );

    // Stage 1: the shared port. Active video always wins; a pending write is
    // granted only on a blank cycle, one per cycle while it stays requested.
    // Out-of-range writes are acknowledged but never reach the RAM.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_fb_addr  <= '0;
            o_fb_wen   <= 1'b0;
            o_fb_wdata <= '0;
            o_wr_ack   <= 1'b0;
        end else begin
            o_fb_wen <= 1'b0;
            o_wr_ack <= 1'b0;
            if (ctl0.active) begin
                o_fb_addr <= cell_addr(ctl0.row, ctl0.col);
            end else if (i_wr_req) begin
                o_fb_addr  <= i_wr_addr;
                o_fb_wdata <= i_wr_data;
                o_fb_wen   <= (i_wr_addr < FB_LIMIT);
                o_wr_ack   <= 1'b1;
            end
        end
    end

    // Stage 1: carry the raster decode alongside the port access
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            active1_reg <= 1'b0;
            hs1_reg     <= 1'b0;
            vs1_reg     <= 1'b0;
        end else begin
            active1_reg <= ctl0.active;
            hs1_reg     <= ctl0.hs;
            vs1_reg     <= ctl0.vs;
        end
    end

    // Stage 2: pin-side timing; syncs are active low
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_de    <= 1'b0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
        end else begin
            o_de    <= active1_reg;
            o_hsync <= ~hs1_reg;
            o_vsync <= ~vs1_reg;
        end
    end

`ifdef FB_SCANOUT_TESTPAT_EN
    // Cell indices delayed to line up with the stage-2 pixel
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            row1_reg <= '0;
            col1_reg <= '0;
            row2_reg <= '0;
            col2_reg <= '0;
        end else begin
            row1_reg <= ctl0.row[4:0];
            col1_reg <= ctl0.col;
            row2_reg <= row1_reg;
            col2_reg <= col1_reg;
        end
    end
`endif

    // Pixel select: the RAM output register is the stage-2 data register;
    // blank and write cycles (de low) force black so stale reads never escape
    always_comb begin
        o_pixel = '0;
        if (o_de) begin
`ifdef FB_SCANOUT_TESTPAT_EN
            if (i_test_pat) begin
                o_pixel = {row2_reg, 3'b000} ^ {1'b0, col2_reg};
            end else begin
                o_pixel = i_fb_rdata;
            end
`else
            o_pixel = i_fb_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a stimulus/model process computes the
// expected port and pin values from raster arithmetic and pushes them into
// queues; a negedge monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_fb_scanout;
    import fb_pkg::*;

    localparam int SEG0_CYCLES = 16300;   // stops at vcnt=20, hcnt=300
    localparam int SEG1_CYCLES = 16000;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [12:0] o_fb_addr;
    logic        o_fb_wen;
    logic [7:0]  o_fb_wdata;
    logic [7:0]  i_fb_rdata;
    logic        i_wr_req = 1'b0;
    logic [12:0] i_wr_addr = '0;
    logic [7:0]  i_wr_data = '0;
    logic        o_wr_ack;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [7:0]  o_pixel;
    logic        test_pat = 1'b0;

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .o_fb_addr  (o_fb_addr),
        .o_fb_wen   (o_fb_wen),
        .o_fb_wdata (o_fb_wdata),
        .i_fb_rdata (i_fb_rdata),
        .i_wr_req   (i_wr_req),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
`ifdef FB_SCANOUT_TESTPAT_EN
        .i_test_pat (test_pat),
`endif
        .o_wr_ack   (o_wr_ack),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_de       (o_de),
        .o_pixel    (o_pixel)
    );

    // Frame buffer RAM with registered read; unwritten cells hold addr[7:0]
    logic [7:0] ram [0:8191];
    bit         ram_written [0:8191];
    always @(posedge clk) begin
        if (o_fb_wen) begin
            ram[o_fb_addr]         <= o_fb_wdata;
            ram_written[o_fb_addr] <= 1'b1;
        end
        i_fb_rdata <= ram_written[o_fb_addr] ? ram[o_fb_addr] : o_fb_addr[7:0];
    end

    typedef struct {
        int         c;
        int         x;
        int         y;
        int         seg;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] pix;
    } pin_exp_t;

    typedef struct {
        int          c;
        logic        ack;
        logic        wen;
        logic [12:0] addr;
        logic [7:0]  wdata;
    } port_exp_t;

    typedef struct {
        int          start;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_req_t;

    pin_exp_t  pin_q[$];
    port_exp_t port_q[$];
    wr_req_t   req_q[$];

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Reference model state (stimulus process only)
    logic [7:0]  ref_mem [0:4799];
    int          seg = 0;
    bit          req_on = 1'b0;
    wr_req_t     cur;
    logic [12:0] last_addr;
    logic [7:0]  last_wdata;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Restart the model at raster (0,0): two cycles of reset-valued pins
    task automatic model_restart();
        pin_exp_t  p;
        port_exp_t q;
        pin_q.delete();
        port_q.delete();
        req_q.delete();
        req_on     = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            p = '{c: i, x: -1, y: -1, seg: seg, de: 1'b0, hs: 1'b1, vs: 1'b1, pix: 8'h00};
            pin_q.push_back(p);
        end
        q = '{c: 0, ack: 1'b0, wen: 1'b0, addr: 13'd0, wdata: 8'h00};
        port_q.push_back(q);
    endtask

    // One raster cycle: drive the writer, then predict the port (c+1) and pins (c+2)
    task automatic do_cycle(input int c);
        int         h;
        int         v;
        bit         act;
        logic [7:0] fetched;
        pin_exp_t   p;
        port_exp_t  q;
        h = c % H_TOTAL;
        v = (c / H_TOTAL) % V_TOTAL;
        act = (h < H_ACTIVE) && (v < V_ACTIVE);
        fetched = 8'h00;

        if (!req_on && req_q.size() > 0 && req_q[0].start <= c) begin
            cur    = req_q.pop_front();
            req_on = 1'b1;
        end
        i_wr_req  = req_on;
        i_wr_addr = req_on ? cur.addr : 13'($urandom);
        i_wr_data = req_on ? cur.data : 8'($urandom);

        q = '{c: c + 1, ack: 1'b0, wen: 1'b0, addr: last_addr, wdata: last_wdata};
        if (act) begin
            q.addr  = 13'((v / 8) * FB_COLS + (h / 8));
            fetched = ref_mem[(v / 8) * FB_COLS + (h / 8)];
        end else if (req_on) begin
            q.ack   = 1'b1;
            q.addr  = cur.addr;
            q.wdata = cur.data;
            q.wen   = (cur.addr < 13'd4800);
            if (q.wen) ref_mem[cur.addr] = cur.data;
            req_on = 1'b0;
        end
        last_addr  = q.addr;
        last_wdata = q.wdata;
        port_q.push_back(q);

        p.c   = c + 2;
        p.x   = h;
        p.y   = v;
        p.seg = seg;
        p.de  = act;
        p.hs  = !(h >= 656 && h <= 751);
        p.vs  = !(v >= 490 && v <= 491);
        if (!act)          p.pix = 8'h00;
        else if (test_pat) p.pix = 8'((((v / 8) % 32) * 8) ^ (h / 8));
        else               p.pix = fetched;
        pin_q.push_back(p);
    endtask

    task automatic add_req(input int start, input logic [12:0] addr, input logic [7:0] data);
        wr_req_t r;
        r = '{start: start, addr: addr, data: data};
        req_q.push_back(r);
    endtask

    task automatic add_random_reqs(input int first, input int n);
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) a = 13'($urandom_range(4800, 8191));
            else                           a = 13'($urandom_range(0, 4799));
            add_req(first + i * 400 + int'($urandom_range(0, 399)), a, 8'($urandom));
        end
    endtask

    // Stimulus and reference model
    initial begin
        for (int i = 0; i < 4800; i++) ref_mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_de",    {31'd0, o_de},    32'd0);
        check("rst_hsync", {31'd0, o_hsync}, 32'd1);
        check("rst_vsync", {31'd0, o_vsync}, 32'd1);
        check("rst_pixel", {24'd0, o_pixel}, 32'd0);
        check("rst_ack",   {31'd0, o_wr_ack}, 32'd0);
        check("rst_addr",  {19'd0, o_fb_addr}, 32'd0);

        // Segment 0: first 20 lines after power-on reset
        seg = 0;
        model_restart();
        add_req(100, 13'd5, 8'hAA);                 // lands in active video, waits for hcnt=640
        add_req(2 * 800 + 700, 13'd4800, 8'h55);     // out of range: ack, no write
        for (int i = 0; i < 10; i++)
            add_req(3 * 800 + 650, 13'(i), 8'($urandom));
        add_random_reqs(4000, 30);
        i_rst = 1'b0;
        checking = 1'b1;
        for (int c = 0; c < SEG0_CYCLES; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            do_cycle(c);
        end

        // Mid-frame asynchronous reset at vcnt=20, hcnt=300
        @(posedge clk);
        #1;
        checking = 1'b0;
        check("pre_rst_de", {31'd0, o_de}, 32'd1);
        i_rst    = 1'b1;
        i_wr_req = 1'b0;
        #1;
        check("async_rst_de",    {31'd0, o_de},     32'd0);
        check("async_rst_hsync", {31'd0, o_hsync},  32'd1);
        check("async_rst_pixel", {24'd0, o_pixel},  32'd0);
        check("async_rst_wen",   {31'd0, o_fb_wen}, 32'd0);
        check("async_rst_addr",  {19'd0, o_fb_addr}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Segment 1: restart from (0,0) with the memory contents kept
        seg = 1;
`ifdef FB_SCANOUT_TESTPAT_EN
        test_pat = 1'b1;
`endif
        model_restart();
        add_random_reqs(200, 20);
        i_rst = 1'b0;
        checking = 1'b1;
        for (int c = 0; c < SEG1_CYCLES; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            do_cycle(c);
        end
        @(posedge clk);
        #1;
        checking = 1'b0;
        #2;
        check("b2b_acks", max_run, 32'd10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor state
    pin_exp_t  pe;
    port_exp_t qe;
    int        mon_seg = -1;
    logic      prev_hs = 1'b1;
    logic      prev_de = 1'b0;
    int        hs_fall = 0;
    int        fall_cnt = 0;
    int        de_rises = 0;
    int        ack_run = 0;
    int        max_run = 0;
    bit        ack_seen = 1'b0;

    // Pop one pin and one port expectation per cycle and compare
    always @(negedge clk) begin
        if (checking) begin
            if (pin_q.size() == 0 || port_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=%0d/%0d want=nonempty", pin_q.size(), port_q.size());
            end else begin
                pe = pin_q.pop_front();
                qe = port_q.pop_front();
                if (pe.seg != mon_seg) begin
                    mon_seg  = pe.seg;
                    prev_hs  = 1'b1;
                    prev_de  = 1'b0;
                    fall_cnt = 0;
                    de_rises = 0;
                    ack_run  = 0;
                    ack_seen = 1'b0;
                end

                total++;
                if ({o_de, o_hsync, o_vsync, o_pixel} !== {pe.de, pe.hs, pe.vs, pe.pix}) begin
                    bad++;
                    $display("FAIL pins c=%0d x=%0d y=%0d got de=%b hs=%b vs=%b pix=%02h want de=%b hs=%b vs=%b pix=%02h",
                             pe.c, pe.x, pe.y, o_de, o_hsync, o_vsync, o_pixel, pe.de, pe.hs, pe.vs, pe.pix);
                end
                total++;
                if ({o_wr_ack, o_fb_wen, o_fb_addr, o_fb_wdata} !== {qe.ack, qe.wen, qe.addr, qe.wdata}) begin
                    bad++;
                    $display("FAIL port c=%0d got ack=%b wen=%b addr=%0d wdata=%02h want ack=%b wen=%b addr=%0d wdata=%02h",
                             qe.c, o_wr_ack, o_fb_wen, o_fb_addr, o_fb_wdata, qe.ack, qe.wen, qe.addr, qe.wdata);
                end
                if (o_wr_ack)
                    $display("wr ack seg=%0d c=%0d addr=%0d data=%02h wen=%b", pe.seg, qe.c, o_fb_addr, o_fb_wdata, o_fb_wen);

                if (pe.seg == 0 && pe.de) begin
                    if (pe.x == 0  && pe.y == 0) check("px_0_0",  {24'd0, o_pixel}, 32'h00);
                    if (pe.x == 8  && pe.y == 0) check("px_8_0",  {24'd0, o_pixel}, 32'h01);
                    if (pe.x == 0  && pe.y == 8) check("px_0_8",  {24'd0, o_pixel}, 32'h50);
                    if (pe.x == 40 && pe.y == 1) check("px_cell5", {24'd0, o_pixel}, 32'hAA);
                end
`ifdef FB_SCANOUT_TESTPAT_EN
                if (pe.seg == 1 && pe.x == 24 && pe.y == 16)
                    check("testpat_r2c3", {24'd0, o_pixel}, 32'h13);
`endif

                if (prev_hs && !o_hsync) begin
                    if (fall_cnt == 0) check("hs_start", pe.c, 32'd658);
                    else               check("line_period", pe.c - hs_fall, 32'd800);
                    hs_fall = pe.c;
                    fall_cnt++;
                end
                if (!prev_hs && o_hsync && fall_cnt > 0)
                    check("hs_width", pe.c - hs_fall, 32'd96);
                if (!prev_de && o_de) begin
                    if (de_rises == 0) check("first_de", pe.c, 32'd2);
                    de_rises++;
                end

                if (o_wr_ack) begin
                    if (!ack_seen && pe.seg == 0) check("wr5_ack_c", qe.c, 32'd641);
                    ack_seen = 1'b1;
                    ack_run++;
                end else begin
                    if (ack_run > max_run) max_run = ack_run;
                    ack_run = 0;
                end
                prev_hs = o_hsync;
                prev_de = o_de;
            end
        end
    end

endmodule
